// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: run-controlled up/down sweep counter.
//
// A run is started from IDLE. The counter sweeps 0 -> limit -> 0 a
// programmable number of laps. A prescaler divides the step rate. The
// run ends with a one-cycle DONE state and then returns to IDLE.
//
// Optional feature: define COUNT_SEQ_HOLD_EN to add a 'hold' input.
// While hold is high during a run, the prescaler and count freeze and
// tick is suppressed. stop and reset still act. Without the macro the
// port does not exist and the block behaves as if hold were tied low.
//
// Control handshake: start is a level request that is taken only in
// IDLE when stop is low. Taking start latches div_sel, limit and laps
// for the whole run. stop is honoured in every state and always wins
// over start. No acknowledge is returned; busy/state show acceptance.
module count_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
`ifdef COUNT_SEQ_HOLD_EN
  input  logic             hold,
`endif
  input  logic [2:0]       div_sel,
  input  logic [WIDTH-1:0] limit,
  input  logic [3:0]       laps,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  // Encoding is visible on the state output, so values are fixed.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [2:0]       presc_q, presc_d;
  logic [3:0]       lap_q,   lap_d;

  // Run parameters captured when start is accepted.
  logic [2:0]       div_lat_q,   div_lat_d;
  logic [WIDTH-1:0] limit_lat_q, limit_lat_d;
  logic [3:0]       laps_lat_q,  laps_lat_d;

  logic             hold_w;
  logic             run_w;
  logic             tick_w;
  logic [3:0]       laps_eff;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;
  logic [3:0]       lap_inc;
  logic [2:0]       presc_inc;

`ifdef COUNT_SEQ_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  // Derived run conditions: activity, tick, and step arithmetic.
  always_comb begin
    run_w     = (state_q == S_UP) || (state_q == S_DOWN);
    // The prescaler wraps on the same cycle the tick fires.
    tick_w    = run_w && !hold_w && (presc_q == div_lat_q);
    // A lap count of zero still runs one full sweep.
    laps_eff  = (laps_lat_q == 4'd0) ? 4'd1 : laps_lat_q;
    count_inc = count_q + WIDTH'(1);
    count_dec = count_q - WIDTH'(1);
    lap_inc   = lap_q + 4'd1;
    presc_inc = presc_q + 3'd1;
  end

  // Next-state and datapath update; stop overrides everything at the end.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    presc_d     = presc_q;
    lap_d       = lap_q;
    div_lat_d   = div_lat_q;
    limit_lat_d = limit_lat_q;
    laps_lat_d  = laps_lat_q;

    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (start && !stop) begin
          div_lat_d   = div_sel;
          limit_lat_d = limit;
          laps_lat_d  = laps;
          presc_d     = 3'd0;
          lap_d       = 4'd0;
          // A zero limit leaves nothing to sweep: report completion at once.
          state_d     = (limit == '0) ? S_DONE : S_UP;
        end
      end

      S_UP: begin
        if (!hold_w) begin
          if (tick_w) begin
            presc_d = 3'd0;
            count_d = count_inc;
            if (count_inc == limit_lat_q) begin
              state_d = S_DOWN;
            end
          end else begin
            presc_d = presc_inc;
          end
        end
      end

      S_DOWN: begin
        if (!hold_w) begin
          if (tick_w) begin
            presc_d = 3'd0;
            count_d = count_dec;
            if (count_dec == '0) begin
              lap_d   = lap_inc;
              state_d = (lap_inc == laps_eff) ? S_DONE : S_UP;
            end
          end else begin
            presc_d = presc_inc;
          end
        end
      end

      S_DONE: begin
        count_d = '0;
        presc_d = 3'd0;
        lap_d   = 4'd0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        count_d = '0;
        presc_d = 3'd0;
        lap_d   = 4'd0;
      end
    endcase

    // Abort: back to IDLE with run state cleared and no done pulse.
    if (stop) begin
      state_d = S_IDLE;
      count_d = '0;
      presc_d = 3'd0;
      lap_d   = 4'd0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      presc_q     <= 3'd0;
      lap_q       <= 4'd0;
      div_lat_q   <= 3'd0;
      limit_lat_q <= '0;
      laps_lat_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      lap_q       <= lap_d;
      div_lat_q   <= div_lat_d;
      limit_lat_q <= limit_lat_d;
      laps_lat_q  <= laps_lat_d;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    count = count_q;
    state = state_q;
    dir   = (state_q == S_UP);
    busy  = run_w;
    done  = (state_q == S_DONE);
    tick  = tick_w;
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Testbench for count_seq_ctrl. Define COUNT_SEQ_HOLD_EN to also
// exercise the hold input.
module tb_count_seq_ctrl;

  localparam int W  = 8;
  localparam int EW = 3 + W + 20;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         start   = 1'b0;
  logic         stop    = 1'b0;
  logic [2:0]   div_sel = 3'd0;
  logic [W-1:0] limit   = '0;
  logic [3:0]   laps    = 4'd0;
`ifdef COUNT_SEQ_HOLD_EN
  logic         hold    = 1'b0;
`endif
  logic [W-1:0] count;
  logic         dir, tick, busy, done;
  logic [1:0]   state;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  // Event word: {is_done, dir, busy, count, cycle[19:0]}
  logic [EW-1:0] exp_q[$];

  count_seq_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
`ifdef COUNT_SEQ_HOLD_EN
    .hold    (hold),
`endif
    .div_sel (div_sel),
    .limit   (limit),
    .laps    (laps),
    .count   (count),
    .dir     (dir),
    .tick    (tick),
    .busy    (busy),
    .done    (done),
    .state   (state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] mk_ev(input bit is_done, input bit d, input bit b,
                                          input int v, input int c);
    logic [W-1:0] vv;
    logic [19:0]  cc;
    vv = v[W-1:0];
    cc = c[19:0];
    return {is_done, d, b, vv, cc};
  endfunction

  // ---------------- reference model ----------------
  // A run with limit L and n laps (0 counts as 1) is the value list
  // 0..L..0 repeated; one step happens every d+1 non-held cycles,
  // starting with the first cycle after start is taken (cycle s).
  // Each step shows as a tick event carrying the value before the step;
  // the done event lands the cycle after the last step. Events after
  // 'cut' (abort cycle) are not produced.
  task automatic push_run(input int s, input int d, input int lim, input int n,
                          input int cut, input int h0, input int hlen);
    int  neff, c, a, v, tc;
    bit  up, held;
    neff = (n == 0) ? 1 : n;
    if (lim == 0) begin
      if (s <= cut) exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 0, s));
      return;
    end
    c = s;
    a = 0;
    for (int lap = 0; lap < neff; lap++) begin
      for (int st = 0; st < 2 * lim; st++) begin
        up = (st < lim);
        v  = up ? st : (2 * lim - st);
        tc = -1;
        while (tc < 0) begin
          held = (c >= h0) && (c < h0 + hlen);
          if (!held) a++;
          if (!held && a == d + 1) begin
            a  = 0;
            tc = c;
          end
          c++;
        end
        if (tc <= cut) exp_q.push_back(mk_ev(1'b0, up, 1'b1, v, tc));
      end
    end
    if (c <= cut) exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 0, c));
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic take_event(input logic [EW-1:0] got);
    logic [EW-1:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: got %0h expected none (cycle %0d)", got, cyc);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_errors++;
        $display("FAIL event: got %0h expected %0h (cycle %0d)", got, exp, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (tick === 1'b1) take_event(mk_ev(1'b0, dir, busy, int'(count), cyc));
      if (done === 1'b1) take_event(mk_ev(1'b1, dir, busy, int'(count), cyc));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rnd_inputs();
    start   = 1'($urandom_range(0, 1));
    div_sel = 3'($urandom);
    limit   = W'($urandom);
    laps    = 4'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 64'(state), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_busy"},  64'(busy),  64'd0);
    check({tag, "_dir"},   64'(dir),   64'd0);
  endtask

  // Called at posedge+1 of an IDLE cycle. abort_at<0: run to completion.
  // exp_cnt: count expected just before the abort, or during hold cycles.
  task automatic do_run(input int d, input int lim, input int n, input int abort_at,
                        input bit use_rst, input bit scramble, input int exp_cnt,
                        input int h_off, input int h_len, input string tag);
    int s, total, cut, neff, w;
    neff  = (n == 0) ? 1 : n;
    total = (lim == 0) ? 0 : 2 * lim * neff * (d + 1) + h_len;
    s     = cyc + 1;
    cut   = (abort_at >= 0) ? s + abort_at : 32'h3fff_ffff;
    push_run(s, d, lim, n, cut, (h_len > 0) ? s + h_off : -1000, h_len);
    div_sel = 3'(d);
    limit   = W'(lim);
    laps    = 4'(n);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (abort_at >= 0) begin
      repeat (abort_at) begin
        if (scramble) rnd_inputs();
        @(posedge clk); #1;
      end
      start = 1'b0;
      if (exp_cnt >= 0) begin
        @(negedge clk);
        check({tag, "_pre_abort_count"}, 64'(count), 64'(exp_cnt));
      end
      if (use_rst) rst_n = 1'b0;
      else         stop  = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      @(negedge clk);
      check_idle({tag, "_abort"});
      if (use_rst) begin
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_no_late_events"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end else begin
      if (scramble || h_len > 0) begin
        for (int k = 0; k <= total; k++) begin
          if (scramble) rnd_inputs();
`ifdef COUNT_SEQ_HOLD_EN
          hold = (h_len > 0) && (k >= h_off) && (k < h_off + h_len);
`endif
          if ((h_len > 0) && (k >= h_off) && (k < h_off + h_len)) begin
            @(negedge clk);
            check({tag, "_hold_count"}, 64'(count), 64'(exp_cnt));
            check({tag, "_hold_tick"},  64'(tick),  64'd0);
          end
          @(posedge clk); #1;
        end
        start = 1'b0;
`ifdef COUNT_SEQ_HOLD_EN
        hold = 1'b0;
`endif
      end
      w = 0;
      while (exp_q.size() != 0 && w < total + 20) begin
        @(negedge clk); #1;
        w++;
      end
      if (exp_q.size() != 0) begin
        check({tag, "_timeout_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
      end
      @(negedge clk);
      check_idle({tag, "_end"});
      @(posedge clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d, lim, n, tot, ab;
    bit ur;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset_tick", 64'(tick), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Basic run, divider, boundaries
    do_run(0, 3, 1, -1, 1'b0, 1'b0, -1, 0, 0, "basic");
    do_run(2, 2, 2, -1, 1'b0, 1'b0, -1, 0, 0, "divider");
    do_run(0, 0, 1, -1, 1'b0, 1'b0, -1, 0, 0, "limit0");
    do_run(1, 2, 0, -1, 1'b0, 1'b0, -1, 0, 0, "laps0");
    do_run(7, 1, 1, -1, 1'b0, 1'b0, -1, 0, 0, "maxdiv");

    // Abort paths
    do_run(0, 5, 1, 2, 1'b0, 1'b0, 2, 0, 0, "stop_up");
    do_run(1, 3, 2, 9, 1'b1, 1'b0, -1, 0, 0, "reset_mid");

    // start and stop together in IDLE: stop wins
    start = 1'b1;
    stop  = 1'b1;
    limit = W'(4);
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    check_idle("start_stop");
    @(posedge clk); #1;

    // Mid-run input changes and start pulses are ignored
    do_run(0, 3, 1, -1, 1'b0, 1'b1, -1, 0, 0, "scramble");

`ifdef COUNT_SEQ_HOLD_EN
    do_run(1, 4, 1, -1, 1'b0, 1'b0, 2, 4, 5, "hold");
`endif

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      d   = $urandom_range(0, 3);
      lim = $urandom_range(0, 6);
      n   = $urandom_range(0, 3);
      tot = (lim == 0) ? 0 : 2 * lim * ((n == 0) ? 1 : n) * (d + 1);
      ab  = -1;
      ur  = 1'b0;
      if (lim > 0 && $urandom_range(0, 2) == 0) begin
        ab = $urandom_range(0, tot);
        ur = 1'($urandom_range(0, 1));
      end
      do_run(d, lim, n, ab, ur, 1'b1, -1, 0, 0, "random");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: width of the counter datapath and of the limit value.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  run request, sampled in IDLE only.
REQ-005 stop  input  1  abort request, sampled in every state.
REQ-006 div_sel  input  3  tick divide select; one tick every div_sel+1 clocks.
REQ-007 limit  input  WIDTH  turn-around value of the up/down sweep.
REQ-008 laps  input  4  number of full up/down sweeps per run.
REQ-009 count  output  WIDTH  current counter value.
REQ-010 dir  output  1  1 = counting up, 0 = counting down or idle.
REQ-011 tick  output  1  one-cycle pulse when count is allowed to step.
REQ-012 busy  output  1  high in states UP and DOWN.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 state  output  2  IDLE=00, UP=01, DOWN=10, DONE=11.

Function
REQ-015 The block SHALL latch div_sel, limit and laps on the clock at which start is accepted; later input changes SHALL be ignored until the next run.
REQ-016 In IDLE with start=1 and stop=0, the block SHALL clear count, the prescaler and the lap counter and enter UP, or enter DONE if the latched limit is 0.
REQ-017 start while not in IDLE SHALL be ignored.
REQ-018 When start and stop are both high in IDLE, stop SHALL win and the block SHALL remain in IDLE.
REQ-019 The prescaler SHALL count 0..div_lat in UP/DOWN; tick SHALL be high exactly when prescaler==div_lat, and the prescaler SHALL return to 0 on that cycle.
REQ-020 div_lat=0 SHALL produce tick on every cycle in UP/DOWN; tick SHALL be 0 in IDLE and DONE.
REQ-021 In UP on tick: count SHALL be incremented; if the new value equals limit_lat, the next state SHALL be DOWN.
REQ-022 In DOWN on tick: count SHALL be decremented; if the new value is 0, the lap counter SHALL be incremented, and the next state SHALL be DONE when the lap count reaches laps_lat, else UP.
REQ-023 A latched laps of 0 SHALL be treated as 1.
REQ-024 count SHALL never wrap: the maximum is limit_lat and the minimum is 0.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE; count SHALL hold 0 in DONE and IDLE.
REQ-026 stop in UP, DOWN or DONE SHALL force IDLE on the next clock, with count, the prescaler and the lap counter cleared and no done pulse.
REQ-027 dir SHALL be 1 only in state UP.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL force state=IDLE and count=0, tick=0, dir=0, busy=0, done=0, with the prescaler, lap counter and latched values all 0.
REQ-029 Reset asserted mid-run SHALL abort the run without a done pulse; reset SHALL take priority over start and stop.

Configuration
REQ-030 With macro COUNT_SEQ_HOLD_EN defined, the block SHALL add input port hold (1 bit); while hold=1 in UP/DOWN, the prescaler and count SHALL freeze and tick SHALL be 0; stop and reset SHALL still take effect.
REQ-031 Without COUNT_SEQ_HOLD_EN, the hold port SHALL not exist and behaviour SHALL equal hold=0.

Verification
REQ-032 Reset: drive rst_n=0 for 2 clocks mid-run -> state=00, count=0, busy=0, no done pulse.
REQ-033 Basic run: div_sel=0, limit=3, laps=1, pulse start -> count steps 1,2,3,2,1,0 on 6 consecutive clocks; dir goes 1 then 0; one done pulse follows; total 8 cycles from start to IDLE.
REQ-034 Divider: div_sel=2, limit=2, laps=2 -> tick every 3rd clock, count sequence 1,2,1,0,1,2,1,0 with 3 clocks between steps; done after the second return to 0.
REQ-035 Boundaries: limit=0 -> IDLE, DONE, IDLE with a single done pulse and no tick; laps=0 -> behaves as laps=1.
REQ-036 Abort/priority: stop at count=2 in UP -> IDLE next clock, count=0, no done; start+stop together in IDLE -> stays IDLE; start during a run -> ignored; input changes mid-run -> ignored.
REQ-037 With COUNT_SEQ_HOLD_EN: hold=1 for 5 clocks at count=2 -> count stays 2 and tick stays 0, then the run resumes with the same prescaler phase.
